// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed eight-digit display scanner.
package display_scan_ctrl_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  digit_en;
        logic [7:0]  points;
    } frame_data_t;

    localparam logic [6:0] SEG_OFF     = 7'h7F;
    localparam logic [7:0] DIG_OFF     = 8'hFF;
    localparam int         DEF_DIV_N   = 100000;
    localparam int         DEF_BLANK_N = 1000;

endpackage

// File: rtl/display_scan_ctrl_hex2seg.sv
// Hex nibble to active-low ABCDEFG segment pattern (segment[6] = A).
module hex2seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit time-multiplexed display scanner with per-slot blanking and
// frame-synchronous double buffering of the displayed data.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int DIV_N   = DEF_DIV_N,
    parameter int BLANK_N = DEF_BLANK_N
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  points,
    input  logic        load,
    output logic [7:0]  digit,
    output logic [6:0]  segment,
    output logic        dp,
    output logic        frame
);

    localparam int                TICK_W     = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DIV_N - 1);
    localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_N - 1);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        slot_q, slot_d;
    scan_state_e       state_q, state_d;
    frame_data_t       shadow_q, shadow_d;
    frame_data_t       pending_q, pending_d;
    logic              pend_flag_q, pend_flag_d;
    logic [7:0]        digit_q, digit_d;
    logic [6:0]        segment_q, segment_d;
    logic              dp_q, dp_d;
    logic              frame_q, frame_d;

    frame_data_t       load_data;
    logic              slot_end;
    logic              frame_wrap;
    logic [3:0]        cur_nibble;
    logic [6:0]        cur_pattern;

    assign load_data  = {value, digit_en, points};
    assign slot_end   = (tick_q == TICK_LAST);
    assign frame_wrap = slot_end && (slot_q == 3'd7);
    assign cur_nibble = shadow_q.value[{slot_q, 2'b00} +: 4];

    hex2seg u_hex2seg (
        .nibble (cur_nibble),
        .seg    (cur_pattern)
    );

    always_comb begin
        tick_d  = slot_end ? '0 : tick_q + 1'b1;
        slot_d  = slot_end ? slot_q + 3'd1 : slot_q;
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (tick_q == BLANK_LAST) state_d = ST_SHOW;
            ST_SHOW:  if (slot_end)             state_d = ST_BLANK;
            default:                            state_d = ST_BLANK;
        endcase
    end

    // Shadow only changes at the frame wrap, so a frame never mixes old and new data.
    always_comb begin
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        if (frame_wrap) begin
            if (load) begin
                shadow_d = load_data;
            end else if (pend_flag_q) begin
                shadow_d = pending_q;
            end
            pend_flag_d = 1'b0;
        end else if (load) begin
            pending_d   = load_data;
            pend_flag_d = 1'b1;
        end
    end

    always_comb begin
        digit_d   = DIG_OFF;
        segment_d = SEG_OFF;
        dp_d      = 1'b1;
        frame_d   = frame_wrap;
        if (state_q == ST_SHOW) begin
            segment_d = cur_pattern;
            dp_d      = ~shadow_q.points[slot_q];
            if (shadow_q.digit_en[slot_q]) begin
                digit_d[slot_q] = 1'b0;
            end
        end
    end

    // NOTE: the data registers are reset along with control so a reset discards pending data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_q      <= '0;
            slot_q      <= '0;
            state_q     <= ST_BLANK;
            shadow_q    <= '0;
            pending_q   <= '0;
            pend_flag_q <= 1'b0;
            digit_q     <= DIG_OFF;
            segment_q   <= SEG_OFF;
            dp_q        <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            tick_q      <= tick_d;
            slot_q      <= slot_d;
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            pend_flag_q <= pend_flag_d;
            digit_q     <= digit_d;
            segment_q   <= segment_d;
            dp_q        <= dp_d;
            frame_q     <= frame_d;
        end
    end

    assign digit   = digit_q;
    assign segment = segment_q;
    assign dp      = dp_q;
    assign frame   = frame_q;

endmodule
